// File: rtl/uart_tx_ctrl_if.sv
// Handshake and baud-counter signals between a UART transmit controller and its environment.
// master: upstream source plus baud counter; slave: the transmit controller.
interface uart_tx_ctrl_if #(
  parameter int unsigned FRAME_WIDTH = 8
);
  logic [FRAME_WIDTH-1:0] tx_data;
  logic                   tx_valid;
  logic                   tx_ready;
  logic                   cnt_done;
  logic                   cnt_en;
  logic                   tx_serial;
  logic                   tx_busy;
  logic                   tx_done;

  modport master (
    output tx_data, tx_valid, cnt_done,
    input  tx_ready, cnt_en, tx_serial, tx_busy, tx_done
  );

  modport slave (
    input  tx_data, tx_valid, cnt_done,
    output tx_ready, cnt_en, tx_serial, tx_busy, tx_done
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: serialises one word per frame (start, data LSB first, stop) paced by cnt_done.
// Optional parity bit between data and stop when UART_TX_PARITY_EN is defined.
module uart_tx_ctrl #(
  parameter int unsigned FRAME_WIDTH = 8,
  parameter int unsigned PARITY_ODD  = 0
) (
  input logic           clk,
  input logic           rst,
  uart_tx_ctrl_if.slave bus
);
  localparam int unsigned IDX_W = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_WIDTH - 1);

  if (FRAME_WIDTH == 0 || FRAME_WIDTH > 16 || PARITY_ODD > 1) begin : g_param_check
    $error("uart_tx_ctrl: unsupported FRAME_WIDTH or PARITY_ODD");
  end

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t                 state;
  logic [FRAME_WIDTH-1:0] shift;
  logic [FRAME_WIDTH-1:0] shift_nxt;
  logic [IDX_W-1:0]       bit_idx;

`ifdef UART_TX_PARITY_EN
  // Parity uses an untouched copy of the word since the shift register is consumed.
  logic [FRAME_WIDTH-1:0] data_cap;
  logic                   parity_bit;
  assign parity_bit = (^data_cap) ^ 1'(PARITY_ODD);
`endif

  assign shift_nxt    = shift >> 1;
  assign bus.tx_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      shift         <= '0;
      bit_idx       <= '0;
      bus.tx_serial <= 1'b1;
      bus.cnt_en    <= 1'b0;
      bus.tx_busy   <= 1'b0;
      bus.tx_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      data_cap      <= '0;
`endif
    end else begin
      bus.tx_done <= 1'b0;
      unique case (state)
        IDLE: begin
          bus.tx_serial <= 1'b1;
          bus.cnt_en    <= 1'b0;
          if (bus.tx_valid && bus.tx_ready) begin
            shift         <= bus.tx_data;
            bit_idx       <= '0;
            bus.cnt_en    <= 1'b1;
            bus.tx_serial <= 1'b0;
            bus.tx_busy   <= 1'b1;
            state         <= START;
`ifdef UART_TX_PARITY_EN
            data_cap      <= bus.tx_data;
`endif
          end
        end
        START: begin
          if (bus.cnt_done) begin
            bus.tx_serial <= shift[0];
            state         <= DATA;
          end
        end
        DATA: begin
          if (bus.cnt_done) begin
            if (bit_idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
              bus.tx_serial <= parity_bit;
              state         <= PARITY;
`else
              bus.tx_serial <= 1'b1;
              state         <= STOP;
`endif
            end else begin
              shift         <= shift_nxt;
              bit_idx       <= bit_idx + IDX_W'(1);
              bus.tx_serial <= shift_nxt[0];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bus.cnt_done) begin
            bus.tx_serial <= 1'b1;
            state         <= STOP;
          end
        end
`endif
        STOP: begin
          if (bus.cnt_done) begin
            state         <= IDLE;
            bus.cnt_en    <= 1'b0;
            bus.tx_busy   <= 1'b0;
            bus.tx_done   <= 1'b1;
            bus.tx_serial <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: two instances (8-bit even, 7-bit odd parity sense) driven by a baud-counter stand-in.
// A time-based frame model checks every output every cycle; directed tests pin the model with literal frames.
`timescale 1ns/1ps
module tb_uart_tx_ctrl;
  localparam int BIT_COUNT = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NB8 = 11;
  localparam int NB7 = 10;
`else
  localparam int NB8 = 10;
  localparam int NB7 = 9;
`endif
  localparam int LAT8 = BIT_COUNT * NB8 + 1;
  localparam int LAT7 = BIT_COUNT * NB7 + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  valid = '0;
  logic [15:0] data [2] = '{16'h0, 16'h0};
  logic        force_done = 1'b0;
  logic [1:0]  ser, en, busy, done, rdy;
  logic [4:0]  cnt [2];
  logic [1:0]  ctr_done;
  logic        cap_rst;
  logic [1:0]  cap_valid;
  logic [15:0] cap_data [2];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  uart_tx_ctrl_if #(.FRAME_WIDTH(8)) bus8 ();
  uart_tx_ctrl_if #(.FRAME_WIDTH(7)) bus7 ();

  assign bus8.tx_data  = data[0][7:0];
  assign bus8.tx_valid = valid[0];
  assign bus8.cnt_done = ctr_done[0] | force_done;
  assign bus7.tx_data  = data[1][6:0];
  assign bus7.tx_valid = valid[1];
  assign bus7.cnt_done = ctr_done[1] | force_done;
  assign ser  = {bus7.tx_serial, bus8.tx_serial};
  assign en   = {bus7.cnt_en,    bus8.cnt_en};
  assign busy = {bus7.tx_busy,   bus8.tx_busy};
  assign done = {bus7.tx_done,   bus8.tx_done};
  assign rdy  = {bus7.tx_ready,  bus8.tx_ready};

  uart_tx_ctrl #(.FRAME_WIDTH(8), .PARITY_ODD(0)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  uart_tx_ctrl #(.FRAME_WIDTH(7), .PARITY_ODD(1)) dut7 (.clk(clk), .rst(rst), .bus(bus7));

  // Baud counter stand-in (registered tick every BIT_COUNT enabled cycles) plus input capture for the model.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst || !en[i]) begin
        cnt[i] <= '0;
        ctr_done[i] <= 1'b0;
      end else if (cnt[i] == 5'(BIT_COUNT - 1)) begin
        cnt[i] <= '0;
        ctr_done[i] <= 1'b1;
      end else begin
        cnt[i] <= cnt[i] + 5'd1;
        ctr_done[i] <= 1'b0;
      end
    end
    cap_rst   <= rst;
    cap_valid <= valid;
    cap_data  <= data;
  end

  task automatic check(input string nm, input int i, input logic [19:0] got, input logic [19:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s dut%0d @%0t: got %h want %h", nm, i, $time, got, want);
    end
  endtask

  // Frame model: t counts edges since the accept edge; start bit spans BIT_COUNT+1 cycles, others BIT_COUNT.
  bit active [2];
  int t [2];
  int nb [2];
  bit frame [2][20];
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int fw, idx;
      bit p, exp_done, exp_ser;
      exp_done = 1'b0;
      fw = (i == 0) ? 8 : 7;
      if (cap_rst) begin
        active[i] = 1'b0;
      end else if (active[i]) begin
        t[i]++;
        if (t[i] == BIT_COUNT * nb[i] + 1) begin
          active[i] = 1'b0;
          exp_done = 1'b1;
        end
      end else if (cap_valid[i]) begin
        active[i] = 1'b1;
        t[i] = 0;
        frame[i][0] = 1'b0;
        p = (i == 1);
        for (int b = 0; b < fw; b++) begin
          frame[i][b + 1] = cap_data[i][b];
          p ^= cap_data[i][b];
        end
        nb[i] = fw + 1;
`ifdef UART_TX_PARITY_EN
        frame[i][nb[i]] = p;
        nb[i]++;
`endif
        frame[i][nb[i]] = 1'b1;
        nb[i]++;
      end
      if (active[i]) begin
        idx = (t[i] <= BIT_COUNT) ? 0 : (t[i] - BIT_COUNT - 1) / BIT_COUNT + 1;
        exp_ser = frame[i][idx];
      end else begin
        exp_ser = 1'b1;
      end
      check("tx_serial", i, ser[i], exp_ser);
      check("cnt_en",    i, en[i],   active[i]);
      check("tx_busy",   i, busy[i], active[i]);
      check("tx_ready",  i, rdy[i],  !active[i]);
      check("tx_done",   i, done[i], exp_done);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input int i, input logic [15:0] d);
    data[i]  = d;
    valid[i] = 1'b1;
    tick();
    valid[i] = 1'b0;
  endtask

  // Called just after the accept edge: samples each bit mid-period, then finds the tx_done edge.
  task automatic run_frame(input int i, input int n, output logic [19:0] bits, output int done_edge);
    int e;
    e = 0;
    bits = '0;
    for (int k = 0; k < n; k++) begin
      int target;
      target = (k == 0) ? 8 : BIT_COUNT + 1 + BIT_COUNT * (k - 1) + 8;
      while (e < target) begin
        @(posedge clk);
        e++;
      end
      @(negedge clk);
      bits[k] = ser[i];
    end
    done_edge = -1;
    while (e < 1000 && done_edge < 0) begin
      @(posedge clk);
      e++;
      @(negedge clk);
      if (done[i]) done_edge = e;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [19:0] bits;
    int de;
    bit saw;

    rst = 1'b1;
    repeat (3) tick();
    check("rst_serial", 0, ser[0], 1'b1);
    check("rst_cnt_en", 0, en[0], 1'b0);
    check("rst_busy",   0, busy[0], 1'b0);
    check("rst_ready",  0, rdy[0], 1'b1);
    rst = 1'b0;
    tick();

    // Single frame, 8'hA5
    send(0, 16'hA5);
    run_frame(0, NB8, bits, de);
`ifdef UART_TX_PARITY_EN
    check("a5_frame", 0, bits, 20'b10101001010);
`else
    check("a5_frame", 0, bits, 20'b1101001010);
`endif
    check("a5_done_latency", 0, 20'(de), 20'(LAT8));

    // Held valid with data change mid-frame, then back-to-back frame
    tick();
    data[0]  = 16'h3C;
    valid[0] = 1'b1;
    tick();
    fork
      run_frame(0, NB8, bits, de);
      begin
        repeat (40) tick();
        data[0] = 16'hFF;
      end
    join
`ifdef UART_TX_PARITY_EN
    check("3c_frame", 0, bits, 20'b10001111000);
`else
    check("3c_frame", 0, bits, 20'b1001111000);
`endif
    check("3c_done_latency", 0, 20'(de), 20'(LAT8));
    check("gap_ready", 0, rdy[0], 1'b1);
    tick();
    check("b2b_busy", 0, busy[0], 1'b1);
    valid[0] = 1'b0;
    run_frame(0, NB8, bits, de);
`ifdef UART_TX_PARITY_EN
    check("ff_frame", 0, bits, 20'b10111111110);
`else
    check("ff_frame", 0, bits, 20'b1111111110);
`endif
    check("ff_done_latency", 0, 20'(de), 20'(LAT8));

    // Reset during data bit 4 of 8'h00
    tick();
    send(0, 16'h00);
    repeat (87) tick();
    check("pre_rst_serial", 0, ser[0], 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_serial", 0, ser[0], 1'b1);
    check("mid_rst_cnt_en", 0, en[0], 1'b0);
    check("mid_rst_busy",   0, busy[0], 1'b0);
    saw = 1'b0;
    repeat (200) begin
      tick();
      if (done[0]) saw = 1'b1;
    end
    check("mid_rst_no_done", 0, saw, 1'b0);
    send(0, 16'h00);
    run_frame(0, NB8, bits, de);
`ifdef UART_TX_PARITY_EN
    check("00_frame", 0, bits, 20'b10000000000);
`else
    check("00_frame", 0, bits, 20'b1000000000);
`endif
    check("00_done_latency", 0, 20'(de), 20'(LAT8));

    // cnt_done stuck high while idle
    tick();
    force_done = 1'b1;
    saw = 1'b0;
    repeat (20) begin
      tick();
      if (done[0] || done[1]) saw = 1'b1;
    end
    check("idle_tick_serial", 0, ser[0], 1'b1);
    check("idle_tick_busy",   0, busy[0], 1'b0);
    check("idle_tick_done",   0, saw, 1'b0);
    force_done = 1'b0;
    tick();

`ifdef UART_TX_PARITY_EN
    // Parity: even sense on 8'h07, odd sense on 7'h07
    send(0, 16'h07);
    run_frame(0, NB8, bits, de);
    check("07_even_frame", 0, bits, 20'b11000001110);
    check("07_even_latency", 0, 20'(de), 20'(LAT8));
    tick();
    send(1, 16'h07);
    run_frame(1, NB7, bits, de);
    check("07_odd_frame", 1, bits, 20'b1000001110);
    tick();
`endif

    // 7-bit frame, 7'h41
    send(1, 16'h41);
    check("w7_ready_low", 1, rdy[1], 1'b0);
    run_frame(1, NB7, bits, de);
`ifdef UART_TX_PARITY_EN
    check("41_frame", 1, bits, 20'b1110000010);
`else
    check("41_frame", 1, bits, 20'b110000010);
`endif
    check("41_done_latency", 1, 20'(de), 20'(LAT7));
    repeat (5) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
UART transmit controller sitting directly above tx_baud_counter. Accepts a parallel word over a valid/ready handshake and serialises it onto tx_serial as an 8N1 frame: start bit, data bits LSB first, stop bit. Drives the baud counter's cnt_en and advances one bit per cnt_done pulse.

Parameters:
FRAME_WIDTH, 8, number of data bits per frame (1..16).
PARITY_ODD, 0, parity sense when UART_TX_PARITY_EN is defined: 0 = even, 1 = odd. Ignored otherwise.

Ports:
clk  input  1  system clock.
rst  input  1  synchronous, active-high reset.
tx_data  input  FRAME_WIDTH  word to transmit; sampled only on accept.
tx_valid  input  1  upstream has a word on tx_data.
tx_ready  output  1  controller can accept a word (IDLE only).
cnt_done  input  1  one-cycle bit-period tick from tx_baud_counter.
cnt_en  output  1  enable to tx_baud_counter; low clears its timer.
tx_serial  output  1  serial line, idle high.
tx_busy  output  1  frame in progress (any state other than IDLE).
tx_done  output  1  one-cycle pulse when the stop bit completes.

Behaviour:
- Reset is synchronous and active-high, on clk, with rst dominant over all other inputs. Reset values: state = IDLE, tx_serial = 1, cnt_en = 0, tx_busy = 0, tx_done = 0, tx_ready = 1, shift register = 0, bit index = 0.
- All outputs are registered except tx_ready, which is the combinational decode (state == IDLE).
- The FSM has the states IDLE, START, DATA, PARITY (present only when the feature is enabled) and STOP.
- IDLE:
  - Drives tx_serial = 1 and cnt_en = 0.
  - An accept is tx_valid && tx_ready at a clk edge.
  - On accept: load the shift register from tx_data, clear the bit index, set cnt_en = 1, tx_serial = 0, tx_busy = 1, and move to START.
  - A cnt_done seen in IDLE is ignored.
- START: on cnt_done, drive tx_serial = shift[0] and move to DATA.
- DATA:
  - On cnt_done with bit index < FRAME_WIDTH-1: shift right, increment the bit index, and drive the next LSB.
  - On cnt_done with bit index == FRAME_WIDTH-1: drive parity and move to PARITY if enabled; otherwise drive tx_serial = 1 and move to STOP.
- STOP: on cnt_done, move to IDLE, set cnt_en = 0, tx_busy = 0, pulse tx_done = 1 for exactly one cycle, and hold tx_serial = 1.
- Bit timing:
  - cnt_en is asserted throughout the frame without dropping, so the counter ticks every BIT_COUNT cycles.
  - Because the counter's cnt_done is registered, the start bit lasts BIT_COUNT+1 clk cycles and every following bit lasts BIT_COUNT cycles.
- Width rule: the bit index is $clog2(FRAME_WIDTH) bits wide, minimum 1, and never wraps within a frame.
- Boundary conditions:
  - tx_valid while busy: tx_ready = 0, so the request is not accepted; upstream must hold the word.
  - Changes to tx_data after accept have no effect on the frame in flight.
  - Back-to-back frames: at least one IDLE cycle separates frames. cnt_en drops for that cycle, which restarts the counter from 0.
  - Reset mid-frame: the next edge yields tx_serial = 1 and cnt_en = 0. The partial frame is abandoned with no tx_done.
  - cnt_done and rst asserted together: rst wins.

Optional Feature:
UART_TX_PARITY_EN
- Defined:
  - The PARITY state exists.
  - The parity bit is the XOR of the captured word, inverted when PARITY_ODD = 1. It is computed from a copy of the word registered at accept.
  - The parity bit is transmitted for one bit period between the last data bit and the stop bit.
  - Frame = FRAME_WIDTH + 3 bits.
- Not defined:
  - No PARITY state and no parity logic.
  - Frame = FRAME_WIDTH + 2 bits.

Test Plan:
All scenarios instantiate tx_baud_counter with BIT_COUNT=16.
1. Reset, then tx_data=8'hA5 with tx_valid=1 for one cycle -> tx_serial pattern 0,1,0,1,0,0,1,0,1,1 (start, LSB first, stop); start bit lasts 17 cycles, other bits 16; tx_done pulses once 161 cycles after the accept edge.
2. tx_valid held high with 8'h3C, then 8'hFF presented mid-frame -> frame carries 8'h3C; 8'hFF accepted only after tx_done, with exactly one IDLE cycle between frames.
3. rst asserted during data bit 4 of 8'h00 -> next cycle tx_serial=1, cnt_en=0, tx_busy=0; no tx_done; the next accept sends a complete frame.
4. cnt_done forced high while in IDLE with tx_valid=0 -> tx_serial stays 1, state stays IDLE, no tx_done.
5. UART_TX_PARITY_EN defined, PARITY_ODD=0, tx_data=8'h07 -> parity bit 1, 11-bit frame, tx_done 177 cycles after accept; with PARITY_ODD=1 -> parity bit 0.
6. FRAME_WIDTH=7, tx_data=7'h41 -> 9-bit frame 0,1,0,0,0,0,0,1,1; tx_ready low throughout the frame.
